test_cam_top: RTL and testbench

//  Top-level camera-to-VGA block: captures RGB444 frames from an OV7670-style parallel camera
//  (2 bytes/pixel, 160x120) into an internal frame buffer, and scans the buffer out on a
//  640x480 VGA raster. Drives camera control pins. Sits directly under the FPGA pins.

---
 rtl/test_cam_top.sv | 244 ++++++++++++++++++++++++
 tb/tb_test_cam_top.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/test_cam_top.sv
// Camera-to-VGA top: captures RGB444 pixels from an OV7670-style parallel
// camera into an on-chip frame buffer and scans them out on a 640x480 raster.
module test_cam_top #(
  parameter int unsigned CAM_W   = 160,
  parameter int unsigned CAM_H   = 120,
  parameter int unsigned AW      = 15,
  parameter int unsigned DW      = 12,
  parameter int unsigned PIX_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CAM_pclk,
  input  logic       CAM_vsync,
  input  logic       CAM_href,
  input  logic       CAM_D0,
  input  logic       CAM_D1,
  input  logic       CAM_D2,
  input  logic       CAM_D3,
  input  logic       CAM_D4,
  input  logic       CAM_D5,
  input  logic       CAM_D6,
  input  logic       CAM_D7,
  output logic       CAM_xclk,
  output logic       CAM_pwdn,
  output logic       CAM_reset,
  output logic       VGA_Hsync_n,
  output logic       VGA_Vsync_n,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B
);

  localparam int unsigned DEPTH    = CAM_W * CAM_H;
  localparam int unsigned RAW      = $clog2(DEPTH);
  localparam int unsigned DIVW     = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned HALF     = PIX_DIV / 2;
  localparam int unsigned CW       = 10;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_SYNC_S = 656;
  localparam int unsigned H_SYNC_E = 751;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_SYNC_S = 490;
  localparam int unsigned V_SYNC_E = 491;
  localparam int unsigned V_TOTAL  = 525;

  typedef struct packed {
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] d;
  } cam_in_t;

  // Byte phase within a pixel: first byte carries red, second carries green/blue.
  typedef enum logic {
    CAP_FIRST  = 1'b0,
    CAP_SECOND = 1'b1
  } cap_state_t;

  cam_in_t          cam_raw_c;
  cam_in_t          sync1;
  cam_in_t          sync2;
  logic             pclk_prev;
  logic             pclk_rise_c;

  cap_state_t       cap_state;
  cap_state_t       cap_state_nx;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    wr_addr_nx;
  logic [3:0]       red_q;
  logic [3:0]       red_nx;
  logic             wr_en_c;
  logic [DW-1:0]    wr_data_c;

  logic [DW-1:0]    mem [DEPTH];
  logic [DW-1:0]    rd_q;
  logic [RAW-1:0]   rd_addr_c;

  logic [DIVW-1:0]  div_q;
  logic             pix_tick_c;
  logic [CW-1:0]    h_cnt;
  logic [CW-1:0]    v_cnt;
  logic             in_act_c;
  logic             in_win_c;
  logic             hs_c;
  logic             vs_c;
  logic             win_q;
  logic             hs_q;
  logic             vs_q;

  logic [DIVW-1:0]  xdiv_q;

  assign CAM_pwdn  = 1'b0;
  assign CAM_reset = 1'b1;

  assign cam_raw_c = {CAM_pclk, CAM_vsync, CAM_href,
                      CAM_D7, CAM_D6, CAM_D5, CAM_D4,
                      CAM_D3, CAM_D2, CAM_D1, CAM_D0};

  // Two-stage synchroniser for every camera input, kept aligned; pclk edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      pclk_prev <= 1'b0;
    end else begin
      sync1     <= cam_raw_c;
      sync2     <= sync1;
      pclk_prev <= sync2.pclk;
    end
  end

  assign pclk_rise_c = sync2.pclk & ~pclk_prev;

  // Capture state register: byte phase, write address, latched red nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_state <= CAP_FIRST;
      wr_addr   <= '0;
      red_q     <= '0;
    end else begin
      cap_state <= cap_state_nx;
      wr_addr   <= wr_addr_nx;
      red_q     <= red_nx;
    end
  end

  // Capture next-state: pair bytes into pixels, saturate the address at the frame end.
  always_comb begin
    cap_state_nx = cap_state;
    wr_addr_nx   = wr_addr;
    red_nx       = red_q;
    wr_en_c      = 1'b0;
    wr_data_c    = DW'({red_q, sync2.d});
    if (pclk_rise_c) begin
      if (sync2.vsync) begin
        wr_addr_nx   = '0;
        cap_state_nx = CAP_FIRST;
      end else if (!sync2.href) begin
        cap_state_nx = CAP_FIRST;
      end else begin
        unique case (cap_state)
          CAP_FIRST: begin
            red_nx       = sync2.d[3:0];
            cap_state_nx = CAP_SECOND;
          end
          CAP_SECOND: begin
            cap_state_nx = CAP_FIRST;
            if (wr_addr < AW'(DEPTH)) begin
              wr_en_c    = 1'b1;
              wr_addr_nx = wr_addr + AW'(1);
            end
          end
          default: cap_state_nx = CAP_FIRST;
        endcase
      end
    end
  end

  // Frame buffer: one write port from capture, one synchronous read port for scan-out.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[RAW'(wr_addr)] <= wr_data_c;
    end
    rd_q <= mem[rd_addr_c];
  end

  assign pix_tick_c = (div_q == DIVW'(PIX_DIV - 1));

  // VGA pixel divider and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div_q <= pix_tick_c ? '0 : div_q + DIVW'(1);
      if (pix_tick_c) begin
        if (h_cnt == CW'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == CW'(V_TOTAL - 1)) ? '0 : v_cnt + CW'(1);
        end else begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end

  // Raster decode: active area, buffer window, sync pulses, buffer read address.
  always_comb begin
    in_act_c  = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
    in_win_c  = in_act_c && (h_cnt < CW'(CAM_W)) && (v_cnt < CW'(CAM_H));
    hs_c      = (h_cnt >= CW'(H_SYNC_S)) && (h_cnt <= CW'(H_SYNC_E));
    vs_c      = (v_cnt >= CW'(V_SYNC_S)) && (v_cnt <= CW'(V_SYNC_E));
    rd_addr_c = '0;
    if (in_win_c) begin
      rd_addr_c = RAW'(32'(v_cnt) * CAM_W + 32'(h_cnt));
    end
  end

  // Delay window and syncs by the RAM read latency so they line up with rd_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      win_q <= in_win_c;
      hs_q  <= hs_c;
      vs_q  <= vs_c;
    end
  end

  // Registered VGA outputs; black outside the captured window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      VGA_Hsync_n <= 1'b1;
      VGA_Vsync_n <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      VGA_Hsync_n <= ~hs_q;
      VGA_Vsync_n <= ~vs_q;
      VGA_R       <= win_q ? rd_q[DW-1 -: 4] : 4'h0;
      VGA_G       <= win_q ? rd_q[DW-5 -: 4] : 4'h0;
      VGA_B       <= win_q ? rd_q[3:0]       : 4'h0;
    end
  end

  // Camera master clock: toggles every half pixel-divider period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xdiv_q   <= '0;
      CAM_xclk <= 1'b0;
    end else if (xdiv_q == DIVW'(HALF - 1)) begin
      xdiv_q   <= '0;
      CAM_xclk <= ~CAM_xclk;
    end else begin
      xdiv_q   <= xdiv_q + DIVW'(1);
    end
  end

endmodule

// File: tb/tb_test_cam_top.sv
// Bench for test_cam_top: drives a camera byte stream, keeps a pixel-level
// picture of what the frame buffer should hold, and checks VGA scan-out.
module tb_test_cam_top;

  // Short frame so that saturation and full-window scan-out fit a short run.
  localparam int unsigned TB_W = 160;
  localparam int unsigned TB_H = 4;
  localparam int unsigned N    = TB_W * TB_H;

  logic       clk;
  logic       rst;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_d;
  logic       cam_xclk;
  logic       cam_pwdn;
  logic       cam_reset;
  logic       hs_n;
  logic       vs_n;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;

  int errors = 0;
  int checks = 0;

  logic [11:0] model_mem [N];
  int          m_addr;
  logic [7:0]  run_q [$];
  logic [7:0]  pat [8];

  test_cam_top #(
    .CAM_W(TB_W), .CAM_H(TB_H), .AW(15), .DW(12), .PIX_DIV(4)
  ) dut (
    .clk(clk), .rst(rst),
    .CAM_pclk(cam_pclk), .CAM_vsync(cam_vsync), .CAM_href(cam_href),
    .CAM_D0(cam_d[0]), .CAM_D1(cam_d[1]), .CAM_D2(cam_d[2]), .CAM_D3(cam_d[3]),
    .CAM_D4(cam_d[4]), .CAM_D5(cam_d[5]), .CAM_D6(cam_d[6]), .CAM_D7(cam_d[7]),
    .CAM_xclk(cam_xclk), .CAM_pwdn(cam_pwdn), .CAM_reset(cam_reset),
    .VGA_Hsync_n(hs_n), .VGA_Vsync_n(vs_n),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One camera byte: pclk low for 2 clk with data set up, then high for 2 clk.
  task automatic pbyte(input logic hr, input logic [7:0] b);
    @(posedge clk); #1;
    cam_pclk = 1'b0;
    cam_href = hr;
    cam_d    = b;
    repeat (2) @(posedge clk);
    #1 cam_pclk = 1'b1;
    @(posedge clk);
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    repeat (6) pbyte(1'b0, 8'h00);
    cam_vsync = 1'b0;
    m_addr = 0;
  endtask

  // Send run_q with href high, then drop href. Bytes pair into pixels from the
  // start of each run; a trailing odd byte is lost; the frame end drops writes.
  task automatic send_run();
    foreach (run_q[i]) pbyte(1'b1, run_q[i]);
    for (int i = 0; i + 1 < run_q.size(); i += 2) begin
      if (m_addr < N) model_mem[m_addr] = {run_q[i][3:0], run_q[i+1]};
      m_addr++;
    end
    repeat (2) pbyte(1'b0, 8'h00);
  endtask

  // Reset (buffer survives), check reset-time outputs, then scan lines from (0,0).
  task automatic reset_and_scan(input int nlines);
    logic [13:0] exp;
    logic [11:0] px;
    cam_vsync = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("reset_outputs", {hs_n, vs_n, vga_r, vga_g, vga_b, cam_xclk, cam_pwdn, cam_reset},
          {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
    for (int v = 0; v < nlines; v++) begin
      for (int h = 0; h < 800; h++) begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        px  = (h < TB_W && v < TB_H) ? model_mem[v * TB_W + h] : 12'h000;
        exp = {!(h >= 656 && h <= 751), 1'b1, px};
        check($sformatf("vga_v%0d_h%0d", v, h), {hs_n, vs_n, vga_r, vga_g, vga_b}, exp);
      end
    end
  endtask

  initial begin
    int cnt;
    pat = '{8'h00, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'hF0, 8'h00, 8'hF0};
    rst = 1'b1;
    cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_d = 8'h00;
    m_addr = 0;

    // Reset values and static pins.
    repeat (20) @(negedge clk);
    check("reset_outputs_init", {hs_n, vs_n, vga_r, vga_g, vga_b, cam_xclk, cam_pwdn, cam_reset},
          {1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;

    // CAM_xclk: 2 clk high, period 4 clk.
    cnt = 0;
    while (cam_xclk !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    check("xclk_rise_seen", cam_xclk, 1'b1);
    cnt = 0;
    while (cam_xclk === 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    check("xclk_high_clk", cnt, 2);
    while (cam_xclk !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    check("xclk_period_clk", cnt, 4);

    // Hsync: low 384 clk, period 3200 clk.
    cnt = 0;
    while (hs_n !== 1'b0 && cnt < 4000) begin @(negedge clk); cnt++; end
    check("hsync_fall_seen", hs_n, 1'b0);
    cnt = 0;
    while (hs_n === 1'b0 && cnt < 1000) begin @(negedge clk); cnt++; end
    check("hsync_low_clk", cnt, 384);
    while (hs_n !== 1'b0 && cnt < 4000) begin @(negedge clk); cnt++; end
    check("hsync_period_clk", cnt, 3200);
    check("vsync_idle_high", vs_n, 1'b1);

    // Frame 1: stripe pattern filling the buffer exactly, then an extra line
    // with different data that must be dropped at saturation.
    frame_start();
    for (int l = 0; l < TB_H; l++) begin
      run_q.delete();
      for (int i = 0; i < 2 * TB_W; i++) run_q.push_back(pat[i % 8]);
      send_run();
    end
    run_q.delete();
    for (int i = 0; i < 2 * TB_W; i++) run_q.push_back(8'hFF);
    send_run();
    reset_and_scan(TB_H + 1);

    // Frame 2: random bytes in random-length href runs (odd lengths break a
    // pixel mid-way), partially overwriting frame 1, then a long extra run.
    cam_vsync = 1'b0;
    frame_start();
    for (int l = 0; l < TB_H; l++) begin
      for (int r = 0; r < 4; r++) begin
        run_q.delete();
        cnt = int'($urandom_range(1, 90));
        for (int i = 0; i < cnt; i++) run_q.push_back(8'($urandom));
        send_run();
      end
    end
    run_q.delete();
    for (int i = 0; i < 2 * TB_W; i++) run_q.push_back(8'($urandom));
    send_run();
    reset_and_scan(TB_H + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
